psram_arbiter: RTL and testbench

- Shares one PSRAM chip (the ram0/ram1 interface of the everdrive core) between two requesters: the MD CPU mapper (CPU port) and the MCU/SPI DMA engine (DMA port).
- Sequences each access as a fixed-length chip-enable window followed by a recovery gap.
- Returns read data and a one-cycle ack to the granted requester.
- Sits between the mapper/DMA logic and the ramN_* signals driven onto the PSRAM pins.

---
 rtl/psram_arb_pkg.sv | 16 +
 rtl/psram_arbiter.sv | 141 ++++++++++++++
 tb/tb_psram_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/psram_arb_pkg.sv
// psram_arb_pkg: shared states, port ids, default timing and request record for psram_arbiter.
package psram_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} arb_state_t;
    typedef enum logic {PORT_CPU, PORT_DMA} arb_port_t;

    localparam int ACC_CYC_DEF = 4;
    localparam int REC_CYC_DEF = 1;

    typedef struct packed {
        logic [1:0]  we;
        logic [22:0] addr;
        logic [15:0] wdat;
    } arb_req_t;

endpackage

// File: rtl/psram_arbiter.sv
// psram_arbiter: shares one PSRAM between the CPU mapper and the DMA engine with fixed access/recovery windows.
// Define PSRAM_ARB_RR_EN for round-robin on simultaneous requests; otherwise the CPU always wins.
module psram_arbiter
    import psram_arb_pkg::*;
#(
    parameter int ACC_CYC = ACC_CYC_DEF,
    parameter int REC_CYC = REC_CYC_DEF
) (
    input  logic        clk50_i,
    input  logic        rst_ni,
    input  logic        cpu_req_i,
    input  logic [1:0]  cpu_we_i,
    input  logic [22:0] cpu_addr_i,
    input  logic [15:0] cpu_wdat_i,
    output logic [15:0] cpu_rdat_o,
    output logic        cpu_ack_o,
    input  logic        dma_req_i,
    input  logic [1:0]  dma_we_i,
    input  logic [22:0] dma_addr_i,
    input  logic [15:0] dma_wdat_i,
    output logic [15:0] dma_rdat_o,
    output logic        dma_ack_o,
    output logic [22:0] ram_addr_o,
    output logic [15:0] ram_dati_o,
    input  logic [15:0] ram_dato_i,
    output logic        ram_ce_o,
    output logic        ram_oe_o,
    output logic        ram_we_lo_o,
    output logic        ram_we_hi_o,
    output logic        busy_o
);

    localparam int CW = $clog2((ACC_CYC > REC_CYC) ? ACC_CYC : REC_CYC) + 1;

    arb_state_t  state_q, state_d;
    arb_port_t   gnt_q, gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [22:0] addr_q, addr_d;
    logic [15:0] dati_q, dati_d, cpu_rdat_q, cpu_rdat_d, dma_rdat_q, dma_rdat_d;
    logic [1:0]  we_q, we_d;
    logic        ce_q, ce_d, oe_q, oe_d, cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d, busy_q, busy_d;
    logic        cpu_win;
    arb_req_t    win;

`ifdef PSRAM_ARB_RR_EN
    // gnt_q holds the last granted port, so a tie goes to the other one
    assign cpu_win = cpu_req_i && (!dma_req_i || gnt_q == PORT_DMA);
`else
    assign cpu_win = cpu_req_i;
`endif
    assign win = cpu_win ? '{we: cpu_we_i, addr: cpu_addr_i, wdat: cpu_wdat_i}
                         : '{we: dma_we_i, addr: dma_addr_i, wdat: dma_wdat_i};

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        dati_d     = dati_q;
        we_d       = we_q;
        ce_d       = ce_q;
        oe_d       = oe_q;
        cpu_rdat_d = cpu_rdat_q;
        dma_rdat_d = dma_rdat_q;
        cpu_ack_d  = 1'b0;
        dma_ack_d  = 1'b0;
        case (state_q)
            IDLE: if (cpu_req_i || dma_req_i) begin
                state_d = ACCESS;
                gnt_d   = cpu_win ? PORT_CPU : PORT_DMA;
                cnt_d   = CW'(ACC_CYC - 1);
                addr_d  = win.addr & 23'h7ffffe;
                dati_d  = win.wdat;
                we_d    = win.we;
                ce_d    = 1'b1;
                oe_d    = win.we == 2'b00;
            end
            ACCESS: if (cnt_q == '0) begin
                state_d   = RECOVER;
                cnt_d     = CW'(REC_CYC - 1);
                ce_d      = 1'b0;
                oe_d      = 1'b0;
                we_d      = 2'b00;
                cpu_ack_d = gnt_q == PORT_CPU;
                dma_ack_d = gnt_q == PORT_DMA;
                cpu_rdat_d = (oe_q && gnt_q == PORT_CPU) ? ram_dato_i : cpu_rdat_q;
                dma_rdat_d = (oe_q && gnt_q == PORT_DMA) ? ram_dato_i : dma_rdat_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            RECOVER: if (cnt_q == '0) state_d = IDLE; else cnt_d = cnt_q - 1'b1;
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk50_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            gnt_q      <= PORT_DMA;
            cnt_q      <= '0;
            addr_q     <= '0;
            dati_q     <= '0;
            we_q       <= '0;
            ce_q       <= 1'b0;
            oe_q       <= 1'b0;
            cpu_rdat_q <= '0;
            dma_rdat_q <= '0;
            cpu_ack_q  <= 1'b0;
            dma_ack_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            dati_q     <= dati_d;
            we_q       <= we_d;
            ce_q       <= ce_d;
            oe_q       <= oe_d;
            cpu_rdat_q <= cpu_rdat_d;
            dma_rdat_q <= dma_rdat_d;
            cpu_ack_q  <= cpu_ack_d;
            dma_ack_q  <= dma_ack_d;
            busy_q     <= busy_d;
        end
    end

    assign cpu_rdat_o  = cpu_rdat_q;
    assign cpu_ack_o   = cpu_ack_q;
    assign dma_rdat_o  = dma_rdat_q;
    assign dma_ack_o   = dma_ack_q;
    assign ram_addr_o  = addr_q;
    assign ram_dati_o  = dati_q;
    assign ram_ce_o    = ce_q;
    assign ram_oe_o    = oe_q;
    assign ram_we_lo_o = we_q[0];
    assign ram_we_hi_o = we_q[1];
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter: randomized self-checking bench for psram_arbiter with a per-access timeline model.
module tb_psram_arbiter;
    import psram_arb_pkg::*;

    localparam int ACC = ACC_CYC_DEF;
    localparam int REC = REC_CYC_DEF;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        rst_n, cpu_req, dma_req, s_req;
    logic [1:0]  cpu_we, dma_we;
    logic [22:0] cpu_addr, dma_addr, ram_addr, s_addr;
    logic [15:0] cpu_wdat, dma_wdat, ram_dato, cpu_rdat, dma_rdat, ram_dati;
    logic [15:0] s_cpu_rdat, s_dma_rdat, s_dati;
    logic        cpu_ack, dma_ack, ram_ce, ram_oe, ram_we_lo, ram_we_hi, busy;
    logic        s_cpu_ack, s_dma_ack, s_ce, s_oe, s_wlo, s_whi, s_busy;

    psram_arbiter dut (
        .clk50_i(clk), .rst_ni(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdat_i(cpu_wdat),
        .cpu_rdat_o(cpu_rdat), .cpu_ack_o(cpu_ack),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdat_i(dma_wdat),
        .dma_rdat_o(dma_rdat), .dma_ack_o(dma_ack),
        .ram_addr_o(ram_addr), .ram_dati_o(ram_dati), .ram_dato_i(ram_dato),
        .ram_ce_o(ram_ce), .ram_oe_o(ram_oe), .ram_we_lo_o(ram_we_lo), .ram_we_hi_o(ram_we_hi),
        .busy_o(busy)
    );

    psram_arbiter #(.ACC_CYC(2), .REC_CYC(3)) sweep (
        .clk50_i(clk), .rst_ni(rst_n),
        .cpu_req_i(s_req), .cpu_we_i(2'b00), .cpu_addr_i(23'h000040), .cpu_wdat_i(16'h0000),
        .cpu_rdat_o(s_cpu_rdat), .cpu_ack_o(s_cpu_ack),
        .dma_req_i(1'b0), .dma_we_i(2'b00), .dma_addr_i(23'h000000), .dma_wdat_i(16'h0000),
        .dma_rdat_o(s_dma_rdat), .dma_ack_o(s_dma_ack),
        .ram_addr_o(s_addr), .ram_dati_o(s_dati), .ram_dato_i(16'h5A5A),
        .ram_ce_o(s_ce), .ram_oe_o(s_oe), .ram_we_lo_o(s_wlo), .ram_we_hi_o(s_whi),
        .busy_o(s_busy)
    );

    int          vec = 0, miss = 0;
    bit          last_cpu = 1'b0;
    logic [15:0] m_cpu_rdat = '0, m_dma_rdat = '0;

    // One granted access from the grant edge to the first IDLE cycle; drop_k is the cycle the winner releases req (0 = never)
    task automatic window(input string name, input int drop_k, input logic [15:0] dato);
        bit c;
        logic [1:0]  we;
        logic [22:0] a;
        logic [15:0] wd;
        logic [77:0] act, exp;
`ifdef PSRAM_ARB_RR_EN
        c = cpu_req && !(dma_req && last_cpu);
`else
        c = cpu_req;
`endif
        we = c ? cpu_we : dma_we;
        a  = c ? cpu_addr : dma_addr;
        wd = c ? cpu_wdat : dma_wdat;
        ram_dato = dato;
        for (int k = 1; k <= ACC + REC + 1; k++) begin
            @(negedge clk);
            if (k == ACC + 1 && we == 2'b00) begin
                if (c) m_cpu_rdat = dato; else m_dma_rdat = dato;
            end
            act = {ram_ce, ram_oe, ram_we_hi, ram_we_lo, cpu_ack, dma_ack, busy, ram_addr, ram_dati, cpu_rdat, dma_rdat};
            exp = {k <= ACC, k <= ACC && we == 2'b00, k <= ACC && we[1], k <= ACC && we[0],
                   k == ACC + 1 && c, k == ACC + 1 && !c, k <= ACC + REC,
                   {a[22:1], 1'b0}, wd, m_cpu_rdat, m_dma_rdat};
            vec++;
            if (act !== exp) begin
                miss++;
                $display("FAIL %s k=%0d win=%s got=%h exp=%h", name, k, c ? "cpu" : "dma", act, exp);
            end
            if (k == drop_k) begin
                if (c) cpu_req = 1'b0; else dma_req = 1'b0;
            end
        end
        last_cpu = c;
    endtask

    task automatic apply_reset(input string name);
        rst_n = 1'b0;
        cpu_req = 1'b0; dma_req = 1'b0; s_req = 1'b0;
        m_cpu_rdat = '0; m_dma_rdat = '0; last_cpu = 1'b0;
        repeat (2) @(negedge clk);
        vec++;
        if ({ram_ce, ram_oe, ram_we_hi, ram_we_lo, cpu_ack, dma_ack, busy, ram_addr, ram_dati, cpu_rdat, dma_rdat, s_ce, s_busy} !== '0) begin
            miss++;
            $display("FAIL %s outputs not cleared: ce=%b busy=%b addr=%h rdat=%h/%h exp all 0", name, ram_ce, busy, ram_addr, cpu_rdat, dma_rdat);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        cpu_we = '0; dma_we = '0; cpu_addr = '0; dma_addr = '0; cpu_wdat = '0; dma_wdat = '0; ram_dato = '0;
        apply_reset("reset");
    endtask

    task automatic test_cpu_read();
        cpu_we = 2'b00; cpu_addr = 23'h000100; cpu_wdat = 16'h0000; cpu_req = 1'b1;
        window("cpu_read", ACC + 1, 16'hBEEF);
    endtask

    task automatic test_dma_byte_write();
        dma_we = 2'b10; dma_addr = 23'($urandom); dma_wdat = 16'h12AB; dma_req = 1'b1;
        window("dma_byte_write", ACC + 1, 16'($urandom));
        dma_we = 2'b01; dma_wdat = 16'($urandom); dma_req = 1'b1;
        window("dma_byte_write_lo", ACC + 1, 16'($urandom));
    endtask

    task automatic test_back_to_back();
        cpu_we = 2'b00; dma_we = 2'b00; cpu_addr = 23'h000200; dma_addr = 23'h000300;
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int r = 0; r < 3; r++) window("back_to_back", 0, 16'($urandom));
        cpu_req = 1'b0; dma_req = 1'b0;
    endtask

    task automatic test_withdraw();
        cpu_we = 2'b11; cpu_addr = 23'($urandom); cpu_wdat = 16'($urandom); cpu_req = 1'b1;
        window("withdraw", 1, 16'($urandom));
    endtask

    task automatic test_reset_mid();
        cpu_we = 2'b01; cpu_addr = 23'h000444; cpu_req = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vec++;
        if ({ram_ce, ram_oe, ram_we_hi, ram_we_lo, cpu_ack, dma_ack, busy} !== 7'b0) begin
            miss++;
            $display("FAIL reset_mid controls got=%b exp=0000000", {ram_ce, ram_oe, ram_we_hi, ram_we_lo, cpu_ack, dma_ack, busy});
        end
        apply_reset("reset_mid_hold");
        cpu_we = 2'b00; cpu_req = 1'b1;
        window("after_reset", ACC + 1, 16'($urandom));
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            int mode = int'($urandom_range(0, 2));
            cpu_we = 2'($urandom); dma_we = 2'($urandom);
            cpu_addr = 23'($urandom); dma_addr = 23'($urandom);
            cpu_wdat = 16'($urandom); dma_wdat = 16'($urandom);
            cpu_req = mode != 1; dma_req = mode != 0;
            while (cpu_req || dma_req) window("random", ACC + 1, 16'($urandom));
        end
    endtask

    task automatic test_sweep();
        logic [11:0] ce_hist = '0;
        int ack_cnt = 0, ack_k = -10;
        s_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            ce_hist[k-1] = s_ce;
            if (s_cpu_ack) begin ack_cnt++; ack_k = k; end
            if (k == ack_k + 1) s_req = 1'b0;
        end
        s_req = 1'b0;
        vec++;
        if (ce_hist !== 12'b0000_0000_0011) begin miss++; $display("FAIL sweep ce pattern got=%b exp=%b", ce_hist, 12'b0000_0000_0011); end
        vec++;
        if (ack_cnt !== 1) begin miss++; $display("FAIL sweep ack count got=%0d exp=1", ack_cnt); end
        vec++;
        if (ack_k !== 3) begin miss++; $display("FAIL sweep ack cycle got=%0d exp=3", ack_k); end
        vec++;
        if (s_cpu_rdat !== 16'h5A5A) begin miss++; $display("FAIL sweep rdat got=%h exp=5a5a", s_cpu_rdat); end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_cpu_read();
        test_dma_byte_write();
        test_back_to_back();
        test_withdraw();
        test_reset_mid();
        test_random();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
